// File: rtl/pulse_qualify.sv
// Synchronizes a level input and qualifies it: a run must persist LEN clocks to be
// accepted and LEN inactive clocks to be released; short active runs are flagged.
module pulse_qualify #(
    parameter string PHASE       = "POSITIVE",
    parameter int    LEN         = 4,
    parameter int    SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall,
    output logic glitch,
    output logic level
);
    localparam logic ACT = (PHASE == "NEGATIVE") ? 1'b0 : 1'b1;
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} state_t;

    logic ds;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ds = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync <= {SYNC_STAGES{~ACT}};
                end else begin
                    sync[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
                end
            end
            assign ds = sync[SYNC_STAGES-1];
        end
    endgenerate

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          act, hit_last;
    logic          q_nxt, fall_nxt, glitch_nxt, level_nxt;

    assign act      = (ds == ACT);
    assign hit_last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            q      <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
            level  <= ~ACT;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q      <= q_nxt;
            fall   <= fall_nxt;
            glitch <= glitch_nxt;
            level  <= level_nxt;
        end
    end

    // cnt counts the samples already seen in the current candidate run, so the
    // sample that matches LAST is the LEN-th one and completes the run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (act) begin
                if (LEN == 1) begin
                    state_nxt = HELD;
                end else begin
                    state_nxt = QUAL;
                    cnt_nxt   = CW'(1);
                end
            end
            QUAL: begin
                if (!act) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (hit_last) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: if (!act) begin
                if (LEN == 1) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REL;
                    cnt_nxt   = CW'(1);
                end
            end
            REL: begin
                if (act) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (hit_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Strobes are derived from the transition being taken, then registered.
    always_comb begin
        q_nxt      = (state == IDLE || state == QUAL) && (state_nxt == HELD);
        fall_nxt   = (state == HELD || state == REL) && (state_nxt == IDLE);
        glitch_nxt = (state == QUAL) && (state_nxt == IDLE);
        level_nxt  = (state_nxt == HELD || state_nxt == REL) ? ACT : ~ACT;
    end
endmodule

// File: tb/tb_pulse_qualify.sv
// Bench for pulse_qualify: a run-length model checks two instances every cycle,
// directed scenarios pin exact strobe edges with literal expectations.
module tb_pulse_qualify;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic d_a = 1'b0;
    logic d_b = 1'b1;
    logic q_a, fall_a, glitch_a, level_a;
    logic q_b, fall_b, glitch_b, level_b;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulse_qualify #(.PHASE("POSITIVE"), .LEN(4), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .d(d_a),
        .q(q_a), .fall(fall_a), .glitch(glitch_a), .level(level_a));

    pulse_qualify #(.PHASE("NEGATIVE"), .LEN(1), .SYNC_STAGES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .d(d_b),
        .q(q_b), .fall(fall_b), .glitch(glitch_b), .level(level_b));

    task automatic check(input string name, input logic actual, input logic want);
        tests++;
        if (actual !== want) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, want, $time);
        end
    endtask

    // Model: a delay line stands in for the synchronizer; the filtered level flips
    // once LEN consecutive samples disagree with it; an active run that ends
    // before flipping the level is a glitch.
    logic line [2][8];
    bit   held [2];
    int   run  [2];
    logic eq [2], ef [2], eg [2], el [2];

    task automatic model_reset(input int i, input logic act);
        for (int k = 0; k < 8; k++) line[i][k] = ~act;
        held[i] = 0; run[i] = 0;
        eq[i] = 0; ef[i] = 0; eg[i] = 0; el[i] = ~act;
    endtask

    task automatic model_step(input int i, input logic dv, input int s, input int len,
                              input logic act);
        logic smp;
        bit   a;
        smp = (s == 0) ? dv : line[i][s-1];
        for (int k = 7; k > 0; k--) line[i][k] = line[i][k-1];
        line[i][0] = dv;
        a = (smp == act);
        eq[i] = 0; ef[i] = 0; eg[i] = 0;
        if (a != held[i]) begin
            run[i]++;
            if (run[i] == len) begin
                held[i] = !held[i];
                run[i]  = 0;
                if (held[i]) eq[i] = 1; else ef[i] = 1;
            end
        end else begin
            if (!held[i] && run[i] > 0) eg[i] = 1;
            run[i] = 0;
        end
        el[i] = held[i] ? act : ~act;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0, 1'b1);
            model_reset(1, 1'b0);
        end else begin
            model_step(0, d_a, 2, 4, 1'b1);
            model_step(1, d_b, 0, 1, 1'b0);
        end
    end

    always @(negedge clk) begin
        check("model_a_q", q_a, eq[0]);
        check("model_a_fall", fall_a, ef[0]);
        check("model_a_glitch", glitch_a, eg[0]);
        check("model_a_level", level_a, el[0]);
        check("model_b_q", q_b, eq[1]);
        check("model_b_fall", fall_b, ef[1]);
        check("model_b_glitch", glitch_b, eg[1]);
        check("model_b_level", level_b, el[1]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_q", q_a, 1'b0);
        check("rst_a_fall", fall_a, 1'b0);
        check("rst_a_glitch", glitch_a, 1'b0);
        check("rst_a_level", level_a, 1'b0);
        check("rst_b_level", level_b, 1'b1);
        rst_n = 1'b1;
        repeat (3) tick();

        // accepted pulse: high edges 0-9
        d_a = 1'b1;
        for (int e = 0; e < 25; e++) begin
            tick();
            check("acc_q", q_a, e == 5);
            check("acc_fall", fall_a, e == 15);
            check("acc_level", level_a, e >= 5 && e < 15);
            check("acc_glitch", glitch_a, 1'b0);
            if (e == 9) d_a = 1'b0;
        end

        // rejected 3-sample pulse
        d_a = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            check("rej_glitch", glitch_a, e == 5);
            check("rej_q", q_a, 1'b0);
            check("rej_level", level_a, 1'b0);
            if (e == 2) d_a = 1'b0;
        end

        // 4-sample pulse right after is accepted
        d_a = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            check("min_q", q_a, e == 5);
            check("min_fall", fall_a, e == 9);
            check("min_glitch", glitch_a, 1'b0);
            if (e == 3) d_a = 1'b0;
        end

        // interrupted release: low for edges 7,8 only
        d_a = 1'b1;
        for (int e = 0; e < 31; e++) begin
            tick();
            check("int_q", q_a, e == 5);
            check("int_fall", fall_a, e == 25);
            check("int_glitch", glitch_a, 1'b0);
            if (e >= 5 && e < 25) check("int_level", level_a, 1'b1);
            if (e == 6) d_a = 1'b0;
            if (e == 8) d_a = 1'b1;
            if (e == 19) d_a = 1'b0;
        end

        // async reset between edges clears a just-fired q and the level
        d_a = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        check("pre_async_q", q_a, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_q", q_a, 1'b0);
        check("async_level", level_a, 1'b0);
        check("async_b_level", level_b, 1'b1);
        rst_n = 1'b1;
        d_a = 1'b0;
        repeat (8) tick();

        // NEGATIVE, LEN=1, SYNC=0
        d_b = 1'b0;
        tick();
        check("neg_q0", q_b, 1'b1);
        check("neg_level0", level_b, 1'b0);
        d_b = 1'b1;
        tick();
        check("neg_fall1", fall_b, 1'b1);
        check("neg_q1", q_b, 1'b0);
        check("neg_level1", level_b, 1'b1);
        tick();
        check("neg_fall2", fall_b, 1'b0);
        d_b = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick();
            check("neg3_q", q_b, e == 0);
            check("neg3_fall", fall_b, e == 3);
            check("neg3_level", level_b, !(e < 3));
            check("neg3_glitch", glitch_b, 1'b0);
            if (e == 2) d_b = 1'b1;
        end

        // reset mid-run at QUAL cnt=2, d held active
        d_a = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            check("mid_q", q_a, e == 5);
            check("mid_glitch", glitch_a, 1'b0);
        end
        d_a = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pulse_qualify.md
# pulse_qualify

Receive-side counterpart of the pulse-stretch block: it synchronizes a possibly asynchronous level input, accepts a pulse only when it has been active for at least LEN consecutive clocks, and converts each accepted assertion into a single-cycle start strobe and a single-cycle end strobe. Sub-LEN runs are rejected and flagged. It sits at the destination-domain end of any link whose source stretches pulses, and also serves as a debouncer for slow external strobes.

## Interface
- PHASE, "POSITIVE": active level of d and level. "POSITIVE" means active high; "NEGATIVE" means active low.
- LEN, 4: minimum accepted run length and release run length, in clocks. Legal range ≥1.
- SYNC_STAGES, 2: synchronizer flops on d. 0 bypasses the synchronizer and is only legal for a same-clock d.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- d  input  1  raw input, PHASE polarity.
- q  output  1  one-cycle active-high strobe on accepted assertion.
- fall  output  1  one-cycle active-high strobe on accepted release.
- glitch  output  1  one-cycle active-high strobe when an active run shorter than LEN is rejected.
- level  output  1  filtered level, PHASE polarity.

## Operation
- **Synchronizer.** A chain of SYNC_STAGES flops, all reset to the inactive level (0 for POSITIVE, 1 for NEGATIVE), produces ds. "Active" means ds equals the PHASE active level.
- **Counter.** cnt has width clog2(LEN+1) and holds 0 at reset.
- **FSM (registered), states IDLE / QUAL / HELD / REL:**
  - IDLE:
    - active sample: go to QUAL with cnt=1.
    - if LEN==1, go straight to HELD instead (assert q, level active).
  - QUAL:
    - active sample with cnt==LEN-1: go to HELD, pulse q, drive level active, clear cnt.
    - other active sample: cnt++.
    - inactive sample: go to IDLE, pulse glitch, clear cnt.
  - HELD:
    - inactive sample: go to REL with cnt=1.
    - if LEN==1, go straight to IDLE instead (pulse fall, level inactive).
  - REL:
    - inactive sample with cnt==LEN-1: go to IDLE, pulse fall, drive level inactive, clear cnt.
    - other inactive sample: cnt++.
    - active sample: go back to HELD, clear cnt, no strobe.
- **Output form.** All outputs are registered. q, fall and glitch are never high together and never high for two consecutive cycles from the same run.
- **Counter bound.** cnt never exceeds LEN-1, so no wrap-around is possible.

## Timing
- **Reset values.** q=0, fall=0, glitch=0, cnt=0, state=IDLE. level=0 for POSITIVE, 1 for NEGATIVE.
- **Reset mid-operation.** Every register, including the synchronizer, returns to its reset value immediately. A partial run is discarded and must restart from cnt=0.
- **Edge numbering.** Edge 0 is the first clk edge that samples d active. ds is valid after edge SYNC_STAGES-1. The FSM takes its first active sample at edge SYNC_STAGES.
- **Assertion latency.** q is high for exactly the cycle following edge SYNC_STAGES+LEN-1. level changes at that same edge. Example: SYNC_STAGES=2, LEN=4 gives edge 5.
- **Release latency.** With edge r the first edge sampling d inactive, fall is high in the cycle after edge r+SYNC_STAGES+LEN-1.
- **Glitch timing.** A run of k<LEN active samples asserts glitch in the cycle after the edge that takes the first inactive FSM sample, i.e. edge SYNC_STAGES+k.
- **Back-to-back behaviour.**
  - Adjacent runs separated by at least LEN inactive samples each produce a full q/fall pair.
  - Shorter gaps are absorbed by REL and produce no strobes.
- **Throughput.** No backpressure. One decision is made per clock.

## Test plan
1. **Reset values.** Apply reset, then release it.
   - POSITIVE: q=fall=glitch=0, level=0.
   - NEGATIVE: level=1.
   - An async rst_n pulse between edges clears outputs before the next edge.
2. **Accepted pulse (POSITIVE, LEN=4, SYNC=2).** d high for edges 0–9, low from edge 10.
   - q high only in the cycle after edge 5; level=1 from edge 5.
   - fall high only after edge 15; level=0 from edge 15.
   - glitch stays 0.
3. **Rejected pulse.** d high for edges 0–2 only.
   - glitch high after edge 5.
   - q, fall and level stay 0.
   - A second, 4-sample pulse that follows must still be accepted.
4. **Interrupted release.** Once level=1, drive d low for 2 edges, then high again.
   - No fall, no glitch; level stays 1.
   - A later full release produces exactly one fall.
5. **NEGATIVE phase, LEN=1, SYNC=0.** d low for 1 edge, then high.
   - q high after edge 0; level=0 after edge 0.
   - fall high after edge 1; level=1 after edge 1.
6. **Reset mid-run.** Pulse rst_n low during QUAL at cnt=2, while d stays active.
   - After reset is released, q fires only after a complete SYNC_STAGES+LEN edge sequence.
   - No glitch is reported for the aborted run.
